// File: rtl/tlk2711_tx_framer.sv
// TLK2711 transmit framer: sync fill, then SOF/header/type/line/length, N payload
// words from the TX FIFO, a 16-bit additive checksum and EOF. All pin outputs registered.
module tlk2711_tx_framer #(
    parameter int MIN_SYNC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_soft_rst,
    input  logic        i_tx_start,
    input  logic [7:0]  i_data_mode,
    input  logic [7:0]  i_end_flag,
    input  logic [15:0] i_line_number,
    input  logic [15:0] i_data_length,
    input  logic        i_data_valid,
    input  logic [15:0] i_data,
    output logic        o_data_ready,
    output logic [15:0] o_2711_txd,
    output logic        o_2711_tkmsb,
    output logic        o_2711_tklsb,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic [15:0] o_tx_frame_cnt,
    output logic        o_underflow,
    output logic        o_start_err
);
    typedef enum logic [3:0] {
        ST_SYNC, ST_HEAD0, ST_HEAD1, ST_TYPE, ST_LINE, ST_LEN, ST_DATA, ST_CHECK, ST_EOF
    } state_t;

    localparam logic [15:0] W_SYNC  = 16'hC5BC;
    localparam logic [15:0] W_SOF   = 16'h5CFB;
    localparam logic [15:0] W_HEAD0 = 16'hEB90;
    localparam logic [15:0] W_HEAD1 = 16'hE116;
    localparam logic [15:0] W_EOF   = 16'hFDFE;
    localparam logic [7:0]  MIN_SYNC_8 = 8'(MIN_SYNC);

    state_t      r_state, w_state_next;
    logic [15:0] r_txd, w_txd_next;
    logic        r_tkmsb, w_tkmsb_next;
    logic        r_tklsb, w_tklsb_next;
    logic        r_ready, w_ready_next;
    logic        r_busy, w_busy_next;
    logic        r_done, w_done_next;
    logic [15:0] r_frame_cnt, w_frame_cnt_next;
    logic        r_underflow, w_underflow_next;
    logic        r_start_err, w_start_err_next;
    logic        r_pending, w_pending_next;
    logic [7:0]  r_sync_cnt, w_sync_cnt_next;
    logic [7:0]  r_mode, w_mode_next;
    logic [7:0]  r_end, w_end_next;
    logic [15:0] r_line, w_line_next;
    logic [15:0] r_len, w_len_next;
    logic [15:0] r_csum, w_csum_next;
    logic [14:0] r_words, w_words_next;

    logic [14:0] w_n_in;
    logic        w_start_bad;
    logic        w_start_ok;
    logic        w_go;
    logic [15:0] w_word;

    always_comb begin
        w_n_in      = i_data_length[15:1];
        // r_busy covers every non-SYNC state plus the EOF cycle itself
        w_start_bad = i_tx_start && (r_busy || r_pending || (w_n_in == 15'd0));
        w_start_ok  = i_tx_start && !w_start_bad;
        w_go        = (r_state == ST_SYNC) && !r_busy && (r_pending || w_start_ok)
                      && (r_sync_cnt >= MIN_SYNC_8);
        w_word      = i_data_valid ? i_data : 16'h0000;

        w_state_next     = r_state;
        w_txd_next       = W_SYNC;
        w_tkmsb_next     = 1'b0;
        w_tklsb_next     = 1'b0;
        w_ready_next     = r_ready;
        w_busy_next      = 1'b1;
        w_done_next      = 1'b0;
        w_frame_cnt_next = r_frame_cnt;
        w_underflow_next = r_underflow;
        w_start_err_next = r_start_err || w_start_bad;
        w_pending_next   = r_pending;
        w_sync_cnt_next  = r_sync_cnt;
        w_mode_next      = r_mode;
        w_end_next       = r_end;
        w_line_next      = r_line;
        w_len_next       = r_len;
        w_csum_next      = r_csum;
        w_words_next     = r_words;

        if (w_start_ok) begin
            w_mode_next = i_data_mode;
            w_end_next  = i_end_flag;
            w_line_next = i_line_number;
            w_len_next  = i_data_length;
        end
        if (w_go) begin
            w_pending_next = 1'b0;
        end else if (w_start_ok) begin
            w_pending_next = 1'b1;
        end

        case (r_state)
            ST_SYNC: begin
                if (w_go) begin
                    w_txd_next   = W_SOF;
                    w_tkmsb_next = 1'b1;
                    w_tklsb_next = 1'b1;
                    w_csum_next  = 16'h0000;
                    w_state_next = ST_HEAD0;
                end else begin
                    w_tklsb_next = 1'b1;
                    w_busy_next  = 1'b0;
                    if (r_sync_cnt != 8'hFF) begin
                        w_sync_cnt_next = r_sync_cnt + 8'd1;
                    end
                end
            end
            ST_HEAD0: begin
                w_txd_next   = W_HEAD0;
                w_state_next = ST_HEAD1;
            end
            ST_HEAD1: begin
                w_txd_next   = W_HEAD1;
                w_state_next = ST_TYPE;
            end
            ST_TYPE: begin
                w_txd_next   = {r_mode, r_end};
                w_state_next = ST_LINE;
            end
            ST_LINE: begin
                w_txd_next   = r_line;
                w_state_next = ST_LEN;
            end
            ST_LEN: begin
                w_txd_next   = r_len;
                w_ready_next = 1'b1;
                w_words_next = r_len[15:1];
                w_state_next = ST_DATA;
            end
            ST_DATA: begin
                // ready is high for the whole DATA state; a missing word becomes zero fill
                w_txd_next   = w_word;
                w_csum_next  = r_csum + w_word;
                w_words_next = r_words - 15'd1;
                if (!i_data_valid) begin
                    w_underflow_next = 1'b1;
                end
                if (r_words == 15'd1) begin
                    w_ready_next = 1'b0;
                    w_state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                w_txd_next   = r_csum;
                w_state_next = ST_EOF;
            end
            ST_EOF: begin
                w_txd_next       = W_EOF;
                w_tkmsb_next     = 1'b1;
                w_tklsb_next     = 1'b1;
                w_done_next      = 1'b1;
                w_frame_cnt_next = r_frame_cnt + 16'd1;
                w_sync_cnt_next  = 8'd0;
                w_state_next     = ST_SYNC;
            end
            default: begin
                w_tklsb_next = 1'b1;
                w_busy_next  = 1'b0;
                w_state_next = ST_SYNC;
            end
        endcase

        if (i_soft_rst) begin
            w_state_next     = ST_SYNC;
            w_txd_next       = W_SYNC;
            w_tkmsb_next     = 1'b0;
            w_tklsb_next     = 1'b1;
            w_ready_next     = 1'b0;
            w_busy_next      = 1'b0;
            w_done_next      = 1'b0;
            w_frame_cnt_next = 16'd0;
            w_underflow_next = 1'b0;
            w_start_err_next = 1'b0;
            w_pending_next   = 1'b0;
            w_sync_cnt_next  = 8'd0;
            w_mode_next      = 8'd0;
            w_end_next       = 8'd0;
            w_line_next      = 16'd0;
            w_len_next       = 16'd0;
            w_csum_next      = 16'd0;
            w_words_next     = 15'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_SYNC;
            r_txd       <= W_SYNC;
            r_tkmsb     <= 1'b0;
            r_tklsb     <= 1'b1;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_frame_cnt <= 16'd0;
            r_underflow <= 1'b0;
            r_start_err <= 1'b0;
            r_pending   <= 1'b0;
            r_sync_cnt  <= 8'd0;
            r_mode      <= 8'd0;
            r_end       <= 8'd0;
            r_line      <= 16'd0;
            r_len       <= 16'd0;
            r_csum      <= 16'd0;
            r_words     <= 15'd0;
        end else begin
            r_state     <= w_state_next;
            r_txd       <= w_txd_next;
            r_tkmsb     <= w_tkmsb_next;
            r_tklsb     <= w_tklsb_next;
            r_ready     <= w_ready_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
            r_frame_cnt <= w_frame_cnt_next;
            r_underflow <= w_underflow_next;
            r_start_err <= w_start_err_next;
            r_pending   <= w_pending_next;
            r_sync_cnt  <= w_sync_cnt_next;
            r_mode      <= w_mode_next;
            r_end       <= w_end_next;
            r_line      <= w_line_next;
            r_len       <= w_len_next;
            r_csum      <= w_csum_next;
            r_words     <= w_words_next;
        end
    end

    assign o_data_ready   = r_ready;
    assign o_2711_txd     = r_txd;
    assign o_2711_tkmsb   = r_tkmsb;
    assign o_2711_tklsb   = r_tklsb;
    assign o_busy         = r_busy;
    assign o_frame_done   = r_done;
    assign o_tx_frame_cnt = r_frame_cnt;
    assign o_underflow    = r_underflow;
    assign o_start_err    = r_start_err;
endmodule
